rd_arb: RTL and testbench
=========================

// Module: rd_arb
// PURPOSE
//  Two-client read arbiter directly downstream of the BIUs: client 0 = imap BIU, client 1 = weight BIU.
//  Grants one locked client at a time to the shared memory read port.
//  Forwards that client's address handshakes and routes in-order read data back to it.
//  Tracks outstanding reads so the grant never moves while responses are still in flight.
// PARAMETERS
//  ADDR_W   32  request address width
//  DATA_W   32  read data width
//  MAX_OUTS 8   max outstanding reads (1..15)
//  OUTS_W   4   outstanding counter width, must hold MAX_OUTS
// PORTS
//  clk             in   1       clock, all logic posedge
//  rst_n           in   1       synchronous active-low reset
//  c0_req          in   1       client0 bus lock request (held for whole transfer)
//  c0_addr         in   ADDR_W  client0 read address
//  c0_vld          in   1       client0 address valid
//  c0_rdy          out  1       client0 address accepted
//  c0_rsp_data     out  DATA_W  client0 read data
//  c0_rsp_vld      out  1       client0 read data valid
//  c0_rsp_rdy      in   1       client0 read data ready
//  c1_*            -    -       same set as c0_* for client1
//  mem_addr        out  ADDR_W  memory read address
//  mem_vld         out  1       memory request valid
//  mem_rdy         in   1       memory request ready
//  mem_rsp_data    in   DATA_W  memory read data (returned in request order)
//  mem_rsp_vld     in   1       memory read data valid
//  mem_rsp_rdy     out  1       memory read data ready
//  gnt_id          out  1       current/last granted client (registered)
//  busy            out  1       1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, gnt_id=0, rr_last=1 (client0 wins first tie), outs=0.
//   All vld/rdy outputs 0; mem_addr, rsp_data are don't-care-free: drive 0 in IDLE.
//  FSM: IDLE, GRANT, DRAIN (registered state).
//  IDLE -> GRANT when c0_req|c1_req.
//   Only one requesting: grant it. Both: grant !rr_last. gnt_id latched on this edge.
//   Grant visible 1 cycle after req sampled; no traffic passes in IDLE.
//  GRANT (sel = gnt_id):
//   mem_vld = c_sel_vld & (outs<MAX_OUTS); mem_addr = c_sel_addr.
//   c_sel_rdy = mem_rdy & (outs<MAX_OUTS); other client rdy=0, rsp_vld=0.
//   c_sel_rsp_vld = mem_rsp_vld; c_sel_rsp_data = mem_rsp_data; mem_rsp_rdy = c_sel_rsp_rdy.
//   Request and response paths are combinational pass-through; no added latency.
//   c_sel_req=0 sampled -> DRAIN, regardless of outs.
//  DRAIN: no new requests (c_sel_rdy=0, mem_vld=0); response routing as in GRANT.
//   outs==0 -> IDLE, rr_last<=gnt_id. Entering DRAIN with outs==0 still spends 1 cycle there.
//  outs counter:
//   +1 on mem_vld&mem_rdy; -1 on mem_rsp_vld&mem_rsp_rdy; both same cycle -> unchanged.
//   Never exceeds MAX_OUTS: issue blocked at MAX_OUTS.
//   A response handshake with outs==0 is a protocol error: counter saturates at 0, data still routed.
//  Lock: re-asserting c_sel_req while in DRAIN does not return to GRANT; the client re-arbitrates via IDLE.
//  Other client's req during GRANT/DRAIN is ignored until IDLE.
//  Reset mid-operation: immediate return to reset values next edge; in-flight responses are lost.
//   Memory side must also be reset.
// TESTING
//  c0 only: req=1, 4 addrs 0x100..0x10C, mem latency 3 -> 4 mem handshakes same addrs.
//   4 data to c0 in order; c1_rsp_vld never 1.
//  Both req same cycle after reset -> gnt_id=0 first; after c0 drops req and drain, c1 granted next (gnt_id=1).
//  Memory stalls responses, c0 issues 10 vld -> exactly 8 accepted (c0_rdy=0 at outs=8).
//   One response -> 9th accepted same cycle as outs decrements.
//  c0 drops req with 3 outstanding -> state DRAIN, no new mem_vld.
//   3 responses still reach c0; IDLE the cycle after outs hits 0.
//  Simultaneous req and rsp handshakes with outs=5 -> outs stays 5.
//  rst_n=0 for 1 cycle during GRANT with outs=4 -> state IDLE, outs=0, all rdy/vld outputs 0 next cycle.

Source files
------------

// File: rtl/rd_arb.sv
// rd_arb: two-client locked read arbiter in front of a shared memory read port.
// Grant holds until the client releases and all of its reads have returned.
module rd_arb #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_OUTS = 8,
  parameter int OUTS_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic              c0_vld,
  output logic              c0_rdy,
  output logic [DATA_W-1:0] c0_rsp_data,
  output logic              c0_rsp_vld,
  input  logic              c0_rsp_rdy,
  input  logic              c1_req,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic              c1_vld,
  output logic              c1_rdy,
  output logic [DATA_W-1:0] c1_rsp_data,
  output logic              c1_rsp_vld,
  input  logic              c1_rsp_rdy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_vld,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_vld,
  output logic              mem_rsp_rdy,
  output logic              gnt_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [OUTS_W-1:0] OUTS_MAX = OUTS_W'(MAX_OUTS);
  localparam logic [OUTS_W-1:0] OUTS_ONE = OUTS_W'(1);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              rr_q, rr_d;
  logic [OUTS_W-1:0] outs_q, outs_d;

  logic              sel_req;
  logic              sel_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_rsp_rdy;
  logic              room;
  logic              issue_en;
  logic              route_en;
  logic              inc;
  logic              dec;

  assign sel_req     = gnt_q ? c1_req     : c0_req;
  assign sel_vld     = gnt_q ? c1_vld     : c0_vld;
  assign sel_addr    = gnt_q ? c1_addr    : c0_addr;
  assign sel_rsp_rdy = gnt_q ? c1_rsp_rdy : c0_rsp_rdy;

  assign room     = outs_q < OUTS_MAX;
  assign issue_en = (state_q == S_GRANT) && room;
  assign route_en = (state_q != S_IDLE);

  assign gnt_id = gnt_q;
  assign busy   = route_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b1;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      outs_q  <= outs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (c0_req || c1_req) begin
          state_d = S_GRANT;
          gnt_d   = (c0_req && c1_req) ? ~rr_q : c1_req;
        end
      end
      S_GRANT: begin
        if (!sel_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Lock is released only once every issued read is back.
        if (outs_q == '0) begin
          state_d = S_IDLE;
          rr_d    = gnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_vld     = 1'b0;
    mem_addr    = '0;
    mem_rsp_rdy = 1'b0;
    c0_rdy      = 1'b0;
    c1_rdy      = 1'b0;
    c0_rsp_vld  = 1'b0;
    c1_rsp_vld  = 1'b0;
    c0_rsp_data = '0;
    c1_rsp_data = '0;
    if (issue_en) begin
      mem_vld  = sel_vld;
      mem_addr = sel_addr;
      c0_rdy   = ~gnt_q & mem_rdy;
      c1_rdy   =  gnt_q & mem_rdy;
    end
    if (route_en) begin
      mem_rsp_rdy = sel_rsp_rdy;
      if (gnt_q) begin
        c1_rsp_vld  = mem_rsp_vld;
        c1_rsp_data = mem_rsp_data;
      end else begin
        c0_rsp_vld  = mem_rsp_vld;
        c0_rsp_data = mem_rsp_data;
      end
    end
  end

  assign inc = mem_vld & mem_rdy;
  assign dec = mem_rsp_vld & mem_rsp_rdy;

  always_comb begin
    outs_d = outs_q;
    unique case ({inc, dec})
      2'b10:   outs_d = outs_q + OUTS_ONE;
      // A stray response with nothing outstanding must not wrap.
      2'b01:   outs_d = (outs_q == '0) ? '0 : outs_q - OUTS_ONE;
      default: outs_d = outs_q;
    endcase
  end

endmodule

// File: tb/tb_rd_arb.sv
// tb_rd_arb: directed scenarios for rd_arb against an in-order
// fixed-latency memory model with response stall and stray-response injection.
`timescale 1ns/1ps
module tb_rd_arb;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c0_req = 1'b0, c1_req = 1'b0;
  logic [31:0] c0_addr = '0, c1_addr = '0;
  logic        c0_vld = 1'b0, c1_vld = 1'b0;
  logic        c0_rdy, c1_rdy;
  logic [31:0] c0_rsp_data, c1_rsp_data;
  logic        c0_rsp_vld, c1_rsp_vld;
  logic        c0_rsp_rdy = 1'b1, c1_rsp_rdy = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_vld;
  logic        mem_rdy = 1'b1;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_vld = 1'b0;
  logic        mem_rsp_rdy;
  logic        gnt_id, busy;

  rd_arb #(.ADDR_W(32), .DATA_W(32), .MAX_OUTS(8), .OUTS_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_vld(c0_vld),
    .c0_rdy(c0_rdy), .c0_rsp_data(c0_rsp_data),
    .c0_rsp_vld(c0_rsp_vld), .c0_rsp_rdy(c0_rsp_rdy),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_vld(c1_vld),
    .c1_rdy(c1_rdy), .c1_rsp_data(c1_rsp_data),
    .c1_rsp_vld(c1_rsp_vld), .c1_rsp_rdy(c1_rsp_rdy),
    .mem_addr(mem_addr), .mem_vld(mem_vld), .mem_rdy(mem_rdy),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_vld(mem_rsp_vld),
    .mem_rsp_rdy(mem_rsp_rdy), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          t;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mem_log[$];
  logic [31:0] c0_got[$];
  logic [31:0] c1_got[$];
  bit          c0_seen, c1_seen;
  bit          stall = 1'b0, inject = 1'b0, clr = 1'b0;
  int          cyc = 0;
  int          vecs = 0, errs = 0;
  logic [31:0] nxt;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory response driver: in order, ~3 cycle latency.
  always begin
    @(negedge clk);
    #1;
    if (inject && q.size() == 0) begin
      mem_rsp_vld  = 1'b1;
      mem_rsp_data = 32'hDEAD_BEEF;
    end else if (!stall && q.size() > 0 && q[0].t <= cyc) begin
      mem_rsp_vld  = 1'b1;
      mem_rsp_data = q[0].a ^ KEY;
    end else begin
      mem_rsp_vld  = 1'b0;
      mem_rsp_data = '0;
    end
  end

  // Handshake monitor just before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (clr) begin
      mem_log.delete(); c0_got.delete(); c1_got.delete();
      c0_seen = 1'b0; c1_seen = 1'b0;
    end
    if (!rst_n) begin
      q.delete();
    end else begin
      if (mem_vld && mem_rdy) begin
        q.push_back('{mem_addr, cyc + 3});
        mem_log.push_back(mem_addr);
      end
      if (mem_rsp_vld && mem_rsp_rdy && q.size() > 0)
        void'(q.pop_front());
      if (c0_rsp_vld && c0_rsp_rdy) c0_got.push_back(c0_rsp_data);
      if (c1_rsp_vld && c1_rsp_rdy) c1_got.push_back(c1_rsp_data);
      if (c0_rsp_vld) c0_seen = 1'b1;
      if (c1_rsp_vld) c1_seen = 1'b1;
    end
  end

  task automatic clear_logs();
    clr = 1'b1;
    @(negedge clk);
    #5;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    c0_req = 0; c1_req = 0; c0_vld = 0; c1_vld = 0;
    stall = 0; inject = 0; mem_rdy = 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue0(input int n, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c0_vld = 1'b1;
      c0_addr = nxt;
      #2;
      if (c0_rdy) begin
        acc++;
        nxt += 4;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      #2;
      if (!busy) ok = 1'b1;
    end
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: busy=%0b still, want idle", nm, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; c0_req = 1; c1_req = 1;
    c0_vld = 1; c0_addr = 32'h55;
    repeat (2) @(negedge clk);
    #2;
    vecs++;
    if ({busy, gnt_id, c0_rdy, c1_rdy, mem_vld, mem_rsp_rdy,
         c0_rsp_vld, c1_rsp_vld} !== 8'h00) begin
      errs++;
      $display("FAIL reset_outs: busy%0b gnt%0b rdy%0b%0b mvld%0b",
               busy, gnt_id, c0_rdy, c1_rdy, mem_vld);
    end
    vecs++;
    if (mem_addr !== 32'h0) begin
      errs++;
      $display("FAIL reset_addr: got %h want 0", mem_addr);
    end
    c0_req = 0; c1_req = 0; c0_vld = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #2;
    vecs++;
    if (busy !== 1'b0 || gnt_id !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle: busy=%0b gnt=%0b want 0 0", busy, gnt_id);
    end
  endtask

  task automatic test_c0_only();
    int acc;
    bit bad;
    do_reset();
    clear_logs();
    @(negedge clk);
    c0_req = 1; c0_vld = 1; c0_addr = 32'h100;
    #2;
    vecs++;
    if (c0_rdy !== 1'b0 || mem_vld !== 1'b0) begin
      errs++;
      $display("FAIL idle_no_traffic: rdy=%0b mvld=%0b want 0 0",
               c0_rdy, mem_vld);
    end
    nxt = 32'h100;
    issue0(4, acc);
    vecs++;
    if (acc != 4 || gnt_id !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL c0_issue: acc=%0d gnt=%0b want 4 0", acc, gnt_id);
    end
    @(negedge clk);
    c0_vld = 0;
    repeat (8) @(negedge clk);
    #2;
    bad = (mem_log.size() != 4) || (c0_got.size() != 4);
    for (int i = 0; i < 4 && !bad; i++) begin
      if (mem_log[i] !== 32'h100 + 32'(4 * i)) bad = 1;
      if (c0_got[i] !== ((32'h100 + 32'(4 * i)) ^ KEY)) bad = 1;
    end
    vecs++;
    if (bad) begin
      errs++;
      $display("FAIL c0_data: mem=%0d rsp=%0d want 4 4 in order",
               mem_log.size(), c0_got.size());
    end
    vecs++;
    if (c1_seen) begin
      errs++;
      $display("FAIL c1_quiet: c1_rsp_vld seen=1 want 0");
    end
    c0_req = 0;
    wait_idle("c0_only_idle");
  endtask

  task automatic test_both_req();
    do_reset();
    clear_logs();
    c1_addr = 32'h200;
    @(negedge clk);
    c0_req = 1; c1_req = 1;
    @(negedge clk);
    #2;
    vecs++;
    if (gnt_id !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL both_first: gnt=%0b busy=%0b want 0 1", gnt_id, busy);
    end
    @(negedge clk);
    c0_req = 0;
    @(negedge clk);
    c0_vld = 1; c1_vld = 1;
    #2;
    vecs++;
    if (busy !== 1'b1 || {c0_rdy, c1_rdy, mem_vld} !== 3'b000) begin
      errs++;
      $display("FAIL drain_1cyc: busy=%0b rdy=%0b%0b mvld=%0b",
               busy, c0_rdy, c1_rdy, mem_vld);
    end
    @(negedge clk);
    #2;
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL drain_to_idle: busy=%0b want 0", busy);
    end
    @(negedge clk);
    #2;
    vecs++;
    if ({gnt_id, busy, c1_rdy, c0_rdy, mem_vld} !== 5'b11101 ||
        mem_addr !== 32'h200) begin
      errs++;
      $display("FAIL c1_grant: gnt=%0b rdy=%0b%0b addr=%h want 1 1/0 200",
               gnt_id, c1_rdy, c0_rdy, mem_addr);
    end
    @(negedge clk);
    c0_vld = 0; c1_vld = 0;
    repeat (6) @(negedge clk);
    #2;
    vecs++;
    if (c1_got.size() != 1 || c0_seen) begin
      errs++;
      $display("FAIL c1_route: c1n=%0d c0seen=%0b want 1 0",
               c1_got.size(), c0_seen);
    end else if (c1_got[0] !== (32'h200 ^ KEY)) begin
      errs++;
      $display("FAIL c1_data: got %h want %h", c1_got[0], 32'h200 ^ KEY);
    end
    c1_req = 0;
    wait_idle("c1_idle");
    @(negedge clk);
    c0_req = 1;
    @(negedge clk);
    c0_req = 0;
    wait_idle("c0_short_idle");
    @(negedge clk);
    c0_req = 1; c1_req = 1;
    @(negedge clk);
    #2;
    vecs++;
    if (gnt_id !== 1'b1) begin
      errs++;
      $display("FAIL rr_alternate: gnt=%0b want 1", gnt_id);
    end
    c0_req = 0; c1_req = 0;
    wait_idle("rr_idle");
  endtask

  task automatic test_max_outs();
    int acc;
    bit bad;
    do_reset();
    clear_logs();
    nxt = 32'h1000;
    @(negedge clk);
    c0_req = 1; stall = 1;
    issue0(10, acc);
    vecs++;
    if (acc != 8 || c0_rdy !== 1'b0 || mem_vld !== 1'b0) begin
      errs++;
      $display("FAIL max_outs: acc=%0d rdy=%0b want 8 0", acc, c0_rdy);
    end
    @(negedge clk);
    stall = 0;
    #2;
    vecs++;
    if (c0_rdy !== 1'b0 || c0_rsp_vld !== 1'b1) begin
      errs++;
      $display("FAIL full_rsp: rdy=%0b rvld=%0b want 0 1", c0_rdy, c0_rsp_vld);
    end
    @(negedge clk);
    stall = 1;
    #2;
    vecs++;
    if (c0_rdy !== 1'b1) begin
      errs++;
      $display("FAIL ninth_accept: rdy=%0b want 1", c0_rdy);
    end
    nxt += 4;
    @(negedge clk);
    c0_addr = nxt;
    #2;
    vecs++;
    if (c0_rdy !== 1'b0) begin
      errs++;
      $display("FAIL full_again: rdy=%0b want 0", c0_rdy);
    end
    c0_vld = 0; stall = 0; c0_req = 0;
    wait_idle("max_idle");
    bad = (mem_log.size() != 9) || (c0_got.size() != 9);
    for (int i = 0; i < 9 && !bad; i++) begin
      if (mem_log[i] !== 32'h1000 + 32'(4 * i)) bad = 1;
      if (c0_got[i] !== (mem_log[i] ^ KEY)) bad = 1;
    end
    vecs++;
    if (bad) begin
      errs++;
      $display("FAIL max_data: mem=%0d rsp=%0d want 9 9 in order",
               mem_log.size(), c0_got.size());
    end
  endtask

  task automatic test_drain();
    int acc;
    bit bad_issue, bad;
    do_reset();
    clear_logs();
    nxt = 32'h300;
    @(negedge clk);
    c0_req = 1; stall = 1;
    issue0(3, acc);
    @(negedge clk);
    c0_req = 0; c0_vld = 0;
    @(negedge clk);
    c0_vld = 1; c0_req = 1; stall = 0;
    #2;
    vecs++;
    if (acc != 3 || busy !== 1'b1 || mem_vld !== 1'b0 || c0_rdy !== 1'b0) begin
      errs++;
      $display("FAIL drain_no_issue: acc=%0d busy=%0b mvld=%0b rdy=%0b",
               acc, busy, mem_vld, c0_rdy);
    end
    bad_issue = 0;
    for (int i = 0; i < 30 && c0_got.size() < 3; i++) begin
      @(negedge clk);
      #2;
      if (mem_vld || c0_rdy) bad_issue = 1;
    end
    vecs++;
    if (busy !== 1'b1 || bad_issue || c0_got.size() != 3) begin
      errs++;
      $display("FAIL drain_hold: busy=%0b issue=%0b rsp=%0d want 1 0 3",
               busy, bad_issue, c0_got.size());
    end
    c0_req = 0; c0_vld = 0;
    @(negedge clk);
    #2;
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL drain_idle: busy=%0b want 0", busy);
    end
    bad = (mem_log.size() != 3) || (c0_got.size() != 3);
    for (int i = 0; i < 3 && !bad; i++)
      if (c0_got[i] !== ((32'h300 + 32'(4 * i)) ^ KEY)) bad = 1;
    vecs++;
    if (bad) begin
      errs++;
      $display("FAIL drain_data: mem=%0d rsp=%0d want 3 3 in order",
               mem_log.size(), c0_got.size());
    end
  endtask

  task automatic test_simul();
    int acc, acc2;
    do_reset();
    clear_logs();
    nxt = 32'h400;
    @(negedge clk);
    c0_req = 1; stall = 1;
    issue0(5, acc);
    @(negedge clk);
    stall = 0; c0_addr = nxt;
    #2;
    vecs++;
    if (acc != 5 || c0_rdy !== 1'b1 || c0_rsp_vld !== 1'b1) begin
      errs++;
      $display("FAIL simul_hs: acc=%0d rdy=%0b rvld=%0b want 5 1 1",
               acc, c0_rdy, c0_rsp_vld);
    end
    nxt += 4;
    stall = 1;
    issue0(5, acc2);
    vecs++;
    if (acc2 != 3) begin
      errs++;
      $display("FAIL simul_outs: accepted %0d more want 3", acc2);
    end
    @(negedge clk);
    c0_vld = 0; c0_req = 0; stall = 0;
    wait_idle("simul_idle");
  endtask

  task automatic test_rst_mid();
    int acc;
    do_reset();
    clear_logs();
    nxt = 32'h500;
    @(negedge clk);
    c0_req = 1; stall = 1;
    issue0(4, acc);
    @(negedge clk);
    rst_n = 0; stall = 0;
    @(negedge clk);
    #2;
    vecs++;
    if (acc != 4 || {busy, gnt_id, c0_rdy, c1_rdy, mem_vld, mem_rsp_rdy,
                     c0_rsp_vld, c1_rsp_vld} !== 8'h00) begin
      errs++;
      $display("FAIL rst_mid: acc=%0d busy%0b rdy%0b mvld%0b rrdy%0b",
               acc, busy, c0_rdy, mem_vld, mem_rsp_rdy);
    end
    rst_n = 1; c0_req = 0; c0_vld = 0; stall = 1;
    @(negedge clk);
    c0_req = 1;
    issue0(10, acc);
    vecs++;
    if (acc != 8) begin
      errs++;
      $display("FAIL rst_outs_zero: accepted %0d want 8", acc);
    end
    @(negedge clk);
    c0_vld = 0; c0_req = 0; stall = 0;
    wait_idle("rst_mid_idle");
  endtask

  task automatic test_spurious();
    do_reset();
    clear_logs();
    @(negedge clk);
    c0_req = 1;
    @(negedge clk);
    inject = 1;
    #2;
    vecs++;
    if (c0_rsp_vld !== 1'b1 || c0_rsp_data !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL stray_route: vld=%0b data=%h want 1 deadbeef",
               c0_rsp_vld, c0_rsp_data);
    end
    inject = 0;
    @(negedge clk);
    c0_vld = 1; c0_addr = 32'h600;
    #2;
    vecs++;
    if (c0_rdy !== 1'b1) begin
      errs++;
      $display("FAIL stray_sat: rdy=%0b want 1", c0_rdy);
    end
    @(negedge clk);
    c0_vld = 0; c0_req = 0;
    wait_idle("stray_idle");
    vecs++;
    if (c0_got.size() != 2 || c0_got[1] !== (32'h600 ^ KEY)) begin
      errs++;
      $display("FAIL stray_after: rsp=%0d want 2 ending %h",
               c0_got.size(), 32'h600 ^ KEY);
    end
  endtask

  initial begin
    test_reset();
    test_c0_only();
    test_both_req();
    test_max_outs();
    test_drain();
    test_simul();
    test_rst_mid();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
